// File: rtl/dac_pkg.sv
// Shared types for the PmodDA3 feeder path: DAC code width, code type and pacer FSM states.
package dac_pkg;

   localparam int unsigned DAC_W = 16;

   typedef logic [DAC_W-1:0] dac_code_t;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StStart    = 2'd1,
      StWaitDone = 2'd2
   } dac_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head, occupancy count and full/empty flags.
module sync_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_level == LVL_FULL);
   assign o_empty = (r_level == '0);
   assign o_level = r_level;
   assign o_data  = r_mem[r_rd_ptr];

   // Requests are qualified here so a caller can never corrupt the pointers.
   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_level <= r_level + 1'b1;
         end else if (w_pop && !w_push) begin
            r_level <= r_level - 1'b1;
         end
      end
   end

endmodule

// File: rtl/dac_sample_pacer.sv
// Buffers producer samples and releases one per programmable period to the PmodDA3 driver,
// flagging underrun (no sample at a tick) and overrun (tick while one is already pending).
module dac_sample_pacer
   import dac_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned PERIOD_W   = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          i_enable,
   input  logic [PERIOD_W-1:0]           i_period,
   input  logic [DAC_W-1:0]              i_s_data,
   input  logic                          i_s_valid,
   output logic                          o_s_ready,
   output logic [DAC_W-1:0]              o_dac_data,
   output logic                          o_dac_start,
   input  logic                          i_dac_done,
   output logic                          o_busy,
   output logic                          o_underrun,
   output logic                          o_overrun,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

   dac_state_e          r_state;
   dac_state_e          w_state_next;
   logic [PERIOD_W-1:0] r_cnt;
   logic [PERIOD_W-1:0] w_reload;
   logic                w_tick;
   logic                w_req;
   logic                r_pending;
   logic                w_pending_next;
   dac_code_t           r_dac_data;
   logic                r_underrun;
   logic                r_overrun;
   logic                w_pop;
   logic                w_push;
   logic                w_underrun_set;
   logic                w_overrun_set;
   dac_code_t           w_fifo_head;
   logic                w_fifo_full;
   logic                w_fifo_empty;

   // ---------------- Sample buffer ----------------
   assign o_s_ready = ~w_fifo_full;
   assign w_push    = i_s_valid & o_s_ready;

   sync_fifo #(
      .WIDTH (DAC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (i_s_data),
      .i_pop   (w_pop),
      .o_data  (w_fifo_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_level (o_fifo_level)
   );

   // ---------------- Tick counter ----------------
   // A zero period behaves as one, giving a tick on every enabled cycle.
   assign w_reload = (i_period == '0) ? '0 : i_period - 1'b1;
   assign w_tick   = i_enable & (r_cnt == '0);
   assign w_req    = w_tick | (r_pending & i_enable);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= w_reload;
      end else if (!i_enable || w_tick) begin
         r_cnt <= w_reload;
      end else begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_next   = r_state;
      w_pending_next = r_pending;
      unique case (r_state)
         StIdle: begin
            if (w_req && !w_fifo_empty) begin
               w_state_next = StStart;
            end
         end
         StStart: begin
            w_state_next = StWaitDone;
         end
         StWaitDone: begin
            if (i_dac_done) begin
               w_state_next = StIdle;
            end
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
      // Only one tick is ever remembered; idle always consumes it.
      if (!i_enable || r_state == StIdle) begin
         w_pending_next = 1'b0;
      end else if (w_tick) begin
         w_pending_next = 1'b1;
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      w_pop          = 1'b0;
      w_underrun_set = 1'b0;
      w_overrun_set  = 1'b0;
      if (r_state == StIdle) begin
         w_pop          = w_req & ~w_fifo_empty;
         w_underrun_set = w_req & w_fifo_empty;
      end else begin
         w_overrun_set  = w_tick & r_pending;
      end
   end

   assign o_dac_start = (r_state == StStart);
   assign o_busy      = (r_state != StIdle);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pending  <= 1'b0;
         r_dac_data <= '0;
         r_underrun <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_pending  <= w_pending_next;
         r_underrun <= w_underrun_set;
         r_overrun  <= w_overrun_set;
         if (w_pop) begin
            r_dac_data <= w_fifo_head;
         end
      end
   end

   assign o_dac_data = r_dac_data;
   assign o_underrun = r_underrun;
   assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_dac_sample_pacer.sv
// Directed bench for dac_sample_pacer: pacing, underrun, overrun, full FIFO, reset, period=0.
module tb_dac_sample_pacer;
   import dac_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [15:0] period;
   logic [15:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] dac_data;
   logic        dac_start;
   logic        dac_done;
   logic        busy;
   logic        underrun;
   logic        overrun;
   logic [3:0]  fifo_level;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   dac_sample_pacer #(
      .FIFO_DEPTH (8),
      .PERIOD_W   (16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .i_enable     (enable),
      .i_period     (period),
      .i_s_data     (s_data),
      .i_s_valid    (s_valid),
      .o_s_ready    (s_ready),
      .o_dac_data   (dac_data),
      .o_dac_start  (dac_start),
      .i_dac_done   (dac_done),
      .o_busy       (busy),
      .o_underrun   (underrun),
      .o_overrun    (overrun),
      .o_fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   task automatic wait_start(input int max_cyc, output int t);
      bit seen;
      seen = 1'b0;
      t    = 0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         step();
         if (dac_start === 1'b1) begin
            seen = 1'b1;
            t    = cyc;
         end
      end
      chk("start_seen", 32'(seen), 32'd1);
   endtask

   logic [15:0] exp_b [3];
   int          t;
   int          prev;
   int          n_und;
   int          n_ovr;
   int          n_st;
   int          first;
   int          t2;
   bit          stable;

   initial begin
      exp_b[0] = 16'h0000;
      exp_b[1] = 16'h1234;
      exp_b[2] = 16'hFFFF;
      reset    = 1'b1;
      enable   = 1'b0;
      period   = 16'd100;
      s_data   = '0;
      s_valid  = 1'b0;
      dac_done = 1'b0;
      step();
      step();
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_ready", 32'(s_ready), 32'd1);
      chk("rst_data", 32'(dac_data), 32'd0);
      chk("rst_start", 32'(dac_start), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_underrun", 32'(underrun), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      reset = 1'b0;

      // Basic pacing: three samples, period 100, done 25 cycles after each start
      s_valid = 1'b1;
      s_data  = 16'h0000;
      step();
      s_data  = 16'h1234;
      step();
      s_data  = 16'hFFFF;
      step();
      s_valid = 1'b0;
      chk("basic_level3", 32'(fifo_level), 32'd3);
      enable = 1'b1;
      prev   = 0;
      for (int k = 0; k < 3; k++) begin
         wait_start(150, t);
         chk("basic_data", 32'(dac_data), 32'(exp_b[k]));
         if (k > 0) chk("basic_spacing", 32'(t - prev), 32'd100);
         prev   = t;
         stable = 1'b1;
         for (int i = 0; i < 25; i++) begin
            step();
            if (dac_data !== exp_b[k]) stable = 1'b0;
         end
         dac_done = 1'b1;
         step();
         dac_done = 1'b0;
         chk("basic_stable", 32'(stable), 32'd1);
         chk("basic_idle_after_done", 32'(busy), 32'd0);
      end

      // Underrun: period 50, one sample, then only underrun pulses
      enable  = 1'b0;
      period  = 16'd50;
      s_valid = 1'b1;
      s_data  = 16'hA5A5;
      step();
      s_valid = 1'b0;
      enable  = 1'b1;
      wait_start(80, t);
      chk("und_data", 32'(dac_data), 32'hA5A5);
      n_und = 0;
      n_st  = 0;
      first = 0;
      for (int i = 1; i <= 155; i++) begin
         step();
         if (underrun === 1'b1) begin
            n_und++;
            if (first == 0) first = i;
         end
         if (dac_start === 1'b1) n_st++;
         if (i == 25) dac_done = 1'b1;
         if (i == 26) dac_done = 1'b0;
      end
      chk("und_count", 32'(n_und), 32'd3);
      chk("und_first_at", 32'(first), 32'd50);
      chk("und_no_start", 32'(n_st), 32'd0);
      chk("und_data_held", 32'(dac_data), 32'hA5A5);

      // Overrun: period 10, done 35 cycles after start
      enable  = 1'b0;
      period  = 16'd10;
      s_valid = 1'b1;
      s_data  = 16'h1111;
      step();
      s_data  = 16'h2222;
      step();
      s_valid = 1'b0;
      enable  = 1'b1;
      wait_start(30, t);
      chk("ovr_data1", 32'(dac_data), 32'h1111);
      n_ovr = 0;
      t2    = 0;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (t2 == 0 && overrun === 1'b1) n_ovr++;
         if (t2 == 0 && dac_start === 1'b1) begin
            t2 = i;
            chk("ovr_data2", 32'(dac_data), 32'h2222);
         end
         if (i == 35) dac_done = 1'b1;
         if (i == 36) dac_done = 1'b0;
      end
      chk("ovr_count", 32'(n_ovr), 32'd2);
      chk("ovr_restart_at", 32'(t2), 32'd37);
      enable = 1'b0;
      step();
      dac_done = 1'b1;
      step();
      dac_done = 1'b0;
      step();
      chk("ovr_pending_dropped", 32'(underrun), 32'd0);
      chk("ovr_idle", 32'(busy), 32'd0);

      // Full FIFO with enable low, then period 0 and a simultaneous push/pop
      s_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         s_data = 16'hB000 + 16'(i);
         step();
         if (i == 6) begin
            chk("full_level7", 32'(fifo_level), 32'd7);
            chk("full_ready7", 32'(s_ready), 32'd1);
         end
      end
      chk("full_level8", 32'(fifo_level), 32'd8);
      chk("full_ready8", 32'(s_ready), 32'd0);
      s_data = 16'hBEEF;
      period = 16'd0;
      step();
      chk("full_no_push", 32'(fifo_level), 32'd8);
      s_valid = 1'b0;
      enable  = 1'b1;
      step();
      chk("p0_start", 32'(dac_start), 32'd1);
      chk("p0_data", 32'(dac_data), 32'hB000);
      chk("p0_level_pop", 32'(fifo_level), 32'd7);
      step();
      chk("p0_no_ovr_first", 32'(overrun), 32'd0);
      chk("p0_busy", 32'(busy), 32'd1);
      step();
      chk("p0_ovr_a", 32'(overrun), 32'd1);
      dac_done = 1'b1;
      step();
      chk("p0_ovr_b", 32'(overrun), 32'd1);
      chk("p0_idle", 32'(busy), 32'd0);
      dac_done = 1'b0;
      s_valid  = 1'b1;
      s_data   = 16'hC0DE;
      step();
      chk("pp_start", 32'(dac_start), 32'd1);
      chk("pp_data", 32'(dac_data), 32'hB001);
      chk("pp_level", 32'(fifo_level), 32'd7);
      chk("pp_no_ovr", 32'(overrun), 32'd0);
      s_valid = 1'b0;
      enable  = 1'b0;
      step();
      chk("rm_busy_pre", 32'(busy), 32'd1);

      // Reset in WAIT_DONE with samples buffered
      reset = 1'b1;
      #1;
      chk("rm_start", 32'(dac_start), 32'd0);
      chk("rm_data", 32'(dac_data), 32'd0);
      chk("rm_busy", 32'(busy), 32'd0);
      chk("rm_level", 32'(fifo_level), 32'd0);
      chk("rm_ready", 32'(s_ready), 32'd1);
      step();
      reset  = 1'b0;
      period = 16'd3;
      enable = 1'b1;
      n_st   = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (dac_start === 1'b1) n_st++;
      end
      chk("rm_no_start", 32'(n_st), 32'd0);
      s_valid = 1'b1;
      s_data  = 16'h5A5A;
      step();
      s_valid = 1'b0;
      wait_start(10, t);
      chk("rm_new_data", 32'(dac_data), 32'h5A5A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dac_sample_pacer.md
# dac_sample_pacer

Upstream feeder for the PmodDA3 serial DAC driver. Accepts 16-bit samples from a producer over a valid/ready stream and buffers them in a small FIFO. Releases one sample per programmable sample period by pulsing `dac_start` with stable `dac_data`, then waits for the driver's `done`. Flags underrun (no sample at a tick) and overrun (a tick arrives while the previous conversion is still in flight).

## Interface
- `FIFO_DEPTH`, 8: sample buffer depth, power of two, ≥2.
- `PERIOD_W`, 16: width of the `period` input.
- `clk` in 1: system clock, 50 MHz.
- `reset` in 1: asynchronous, active-high. Clock is `clk`.
- `enable` in 1: pacing enable. Low holds the tick counter and clears the pending tick.
- `period` in PERIOD_W: sample period in clk cycles. 0 is treated as 1.
- `s_data` in 16: sample from the producer.
- `s_valid` in 1: sample valid.
- `s_ready` out 1: FIFO not full.
- `dac_data` out 16: code presented to the DAC driver `data`.
- `dac_start` out 1: one-cycle start request to the DAC driver.
- `dac_done` in 1: conversion-complete from the DAC driver. Level or pulse; the first high cycle counts.
- `busy` out 1: conversion in flight (state ≠ IDLE).
- `underrun` out 1: one-cycle pulse, tick consumed with FIFO empty.
- `overrun` out 1: one-cycle pulse, tick arrived while a tick was already pending.
- `fifo_level` out clog2(FIFO_DEPTH)+1: current occupancy.

## Operation
- **FIFO**
  - Push when `s_valid && s_ready`. `s_ready = (level != FIFO_DEPTH)`.
  - Pop only from the FSM. A push and a pop in the same cycle leave the level unchanged.
  - There is no bypass: a sample pushed in the same cycle as a tick is not visible to that tick.
- **Tick counter**
  - Down-counter reloaded with max(period,1)−1.
  - `tick` is high the cycle the counter is 0 and `enable` is high. The counter reloads on that cycle.
  - While `enable` is low the counter is held at the reload value.
  - A `period` change takes effect at the next reload.
- **FSM states**: IDLE, START, WAIT_DONE.
  - IDLE, with (tick | pending) and FIFO non-empty: pop, register the head into `dac_data`, clear pending, go to START.
  - IDLE, with (tick | pending) and FIFO empty: pulse `underrun`, clear pending, stay in IDLE. `dac_data` keeps its last value.
  - START: `dac_start`=1 for exactly this cycle, then go to WAIT_DONE.
  - WAIT_DONE: on `dac_done`, go to IDLE.
  - A tick while in START or WAIT_DONE sets pending. If pending is already 1, pulse `overrun` instead; pending stays 1 and at most one tick is remembered.
- `dac_data` changes only on a pop. It stays stable from START until the next pop.
- `enable` deasserted mid-conversion: the in-flight conversion completes normally and no new start is issued.
- `dac_done` seen outside WAIT_DONE is ignored.
- **Reset (asynchronous)**
  - FIFO emptied, so `fifo_level`=0 and `s_ready`=1.
  - State IDLE, pending=0.
  - `dac_data`=0, `dac_start`=0, `busy`=0, `underrun`=0, `overrun`=0.
  - Counter loaded with the reload value.
  - Reset mid-conversion abandons the conversion; the DAC driver shares the same reset.

## Timing
- Tick in cycle T, IDLE, FIFO non-empty: `dac_data` updates and `dac_start`=1 in cycle T+1; `busy`=1 from T+1.
- Tick in cycle T, FIFO empty: `underrun`=1 in cycle T+1.
- `dac_done` high in cycle D: state is IDLE in D+1. With pending set and data available, `dac_start` is high in D+2.
- Minimum start-to-start spacing is 3 cycles plus the DAC conversion time.
- Level update:
  - A push in cycle P is reflected in `fifo_level` and `s_ready` in P+1.
  - A pop is reflected in `fifo_level` and `s_ready` one cycle after the pop (in START).
- All outputs are registered except `s_ready`, `busy` and `dac_start`, which are decoded from registered state.

## Structure
- Shared `dac_pkg`: `DAC_W`=16, the FSM state enum (IDLE/START/WAIT_DONE), a typedef for the 16-bit DAC code.
- One sub-module: `sync_fifo` (parameterised width/depth; push/pop/full/empty/level ports). It is reusable by other Pmod feeders.
- The tick counter and FSM live in the top module.

## Test plan
- **Basic pacing.** period=100, push 0x0000, 0x1234, 0xFFFF, then stub `dac_done` 25 cycles after each start. Required: three starts exactly 100 cycles apart with `dac_data` = 0x0000, 0x1234, 0xFFFF, held stable from start to done.
- **Underrun.** period=50, push one sample. Required: one start, then `underrun` pulses at each following tick, `dac_data` stays at the sample, and no further `dac_start`.
- **Overrun.** period=10, stub done 35 cycles after start. Required: the first busy tick sets pending, later busy ticks pulse `overrun`, and the next start occurs at done+2 cycles.
- **Full FIFO.** Hold `s_valid` with enable=0. Required: `s_ready` drops after 8 pushes and `fifo_level`=8. Then a simultaneous push and pop (enable=1) keeps the level at 7.
- **Reset mid-conversion.** Assert reset in WAIT_DONE with 3 samples buffered. Required: immediately `dac_start`=0, `dac_data`=0, `busy`=0, `fifo_level`=0; after release, no start until new data arrives and a tick occurs.
- **period=0.** Required: treated as 1, with ticks every cycle and overrun pulses every cycle during a conversion.
